// File: rtl/acc_sched.sv
// acc_sched: sequencer for the per-column 32-bit psum accumulation FIFO bank.
// Ports:
//   clk, rst        - clock and async active-high reset
//   start_i         - tile start, taken only when idle
//   psum_en_i       - column-0 psum valid from the SA
//   acc_en_o        - per-column accumulate select (0 preload, 1 add)
//   fifo_clr_o      - per-column FIFO pointer clear pulse
//   drain_rd_o      - FIFO read enable during drain (all bits equal)
//   ofmap_valid_o   - ofmap word valid to GLB
//   ofmap_ready_i   - GLB ready
//   pass_idx_o      - current pass index
//   busy_o, done_o  - activity flag and completion pulse
//   err_o           - sticky protocol error
module acc_sched #(
  parameter int PE_SIZE  = 4,
  parameter int COL_NUM  = 70,
  parameter int PASS_NUM = 74,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               psum_en_i,
  output logic [PE_SIZE-1:0] acc_en_o,
  output logic [PE_SIZE-1:0] fifo_clr_o,
  output logic [PE_SIZE-1:0] drain_rd_o,
  output logic               ofmap_valid_o,
  input  logic               ofmap_ready_i,
  output logic [CNT_W-1:0]   pass_idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(COL_NUM - 1);
  localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(PASS_NUM - 1);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(PE_SIZE - 1);
  localparam logic [CNT_W-1:0] COL_CNT   = CNT_W'(COL_NUM);

  typedef enum logic [2:0] {
    IDLE, PRELOAD, ACCUM, SETTLE, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;

  // beat doubles as settle timer and drain read counter
  logic [CNT_W-1:0]   beat, pass;
  logic [PE_SIZE-2:0] acc_sh, clr_sh;
  logic acc_base, clr_base;
  logic rd, hs, feed, err_set;
  logic beat_last, pass_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_base  = 1'b0;
    clr_base  = 1'b0;
    rd        = 1'b0;
    feed      = 1'b0;
    err_set   = 1'b0;
    beat_last = (beat == COL_LAST);
    pass_last = (pass == PASS_LAST);
    hs        = ofmap_valid_o & ofmap_ready_i;
    unique case (state)
      IDLE: begin
        // gated so every output reads 0 while reset is held
        clr_base = start_i & ~rst;
        err_set  = psum_en_i;
        if (start_i) state_nxt = PRELOAD;
      end
      PRELOAD, ACCUM: begin
        acc_base = (state == ACCUM);
        feed     = psum_en_i;
        err_set  = start_i;
        if (psum_en_i && beat_last) begin
          if (pass_last) state_nxt = SETTLE;
          else           state_nxt = ACCUM;
        end
      end
      SETTLE: begin
        // hold the select of the final pass
        acc_base = (PASS_NUM > 1);
        err_set  = start_i | psum_en_i;
        if (beat == SET_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        rd      = (beat < COL_CNT) & (~ofmap_valid_o | ofmap_ready_i);
        err_set = start_i | psum_en_i;
        if (hs && !rd && beat == COL_CNT)
          state_nxt = DONE;
      end
      DONE: begin
        clr_base  = 1'b1;
        err_set   = start_i | psum_en_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat          <= '0;
      pass          <= '0;
      acc_sh        <= '0;
      clr_sh        <= '0;
      ofmap_valid_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      acc_sh <= acc_en_o[PE_SIZE-2:0];
      clr_sh <= fifo_clr_o[PE_SIZE-2:0];
      if (err_set)
        err_o <= 1'b1;
      else if (state == IDLE && start_i)
        err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            beat <= '0;
            pass <= '0;
          end
        end
        PRELOAD, ACCUM: begin
          if (feed) begin
            if (beat_last) begin
              beat <= '0;
              pass <= pass + 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (beat == SET_LAST) beat <= '0;
          else                  beat <= beat + 1'b1;
        end
        DRAIN: begin
          if (rd) beat <= beat + 1'b1;
        end
        default: ;
      endcase
      // FIFO read latency is one cycle; rdata holds while unread
      if (rd)      ofmap_valid_o <= 1'b1;
      else if (hs) ofmap_valid_o <= 1'b0;
    end
  end

  // column j sees the column-0 control j cycles later
  assign acc_en_o   = {acc_sh, acc_base};
  assign fifo_clr_o = {clr_sh, clr_base};
  assign drain_rd_o = {PE_SIZE{rd}};
  assign pass_idx_o = pass;
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);

endmodule

// File: doc/acc_sched.md
Name: acc_sched

Overview:
- Sequencer for the systolic-array accumulation FIFO bank: one 32-bit psum FIFO per output column.
- Counts psum beats per accumulation pass and drives per-column, diagonally skewed accumulate-enable and FIFO pointer-clear signals.
- Runs a valid/ready drain of the finished ofmap tile to the GLB writer.
- Sits between the SA output row, the accumulator FIFO bank and the GLB.

Parameters:
PE_SIZE, 4, number of SA columns / accumulation FIFOs
COL_NUM, 70, psum beats per pass per column (= FIFO depth = weight column count)
PASS_NUM, 74, accumulation passes per tile (ceil(weight rows / PE_SIZE)), >= 1
CNT_W, 8, width of beat and pass counters; 2^CNT_W > max(COL_NUM, PASS_NUM)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle tile start; honoured only in IDLE
psum_en_i  in  1  column-0 psum valid from SA; column j is valid j cycles later
acc_en_o  out  PE_SIZE  per-column feedback select: 0 = preload psum, 1 = add FIFO data
fifo_clr_o  out  PE_SIZE  per-column one-cycle FIFO pointer clear pulse
drain_rd_o  out  PE_SIZE  FIFO read enable during drain, same value on all bits
ofmap_valid_o  out  1  drained ofmap word valid to GLB
ofmap_ready_i  in  1  GLB accepts word when valid & ready
pass_idx_o  out  CNT_W  current pass index
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse at tile completion
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, skew registers 0, all outputs 0.
- States: IDLE, PRELOAD, ACCUM, SETTLE, DRAIN, DONE.

IDLE:
- start_i=1 -> PRELOAD, pass=0, beat=0.
- fifo_clr_o base pulse asserted in the same cycle.
- err_o cleared.

Skew rule:
- acc_en_o[j] and fifo_clr_o[j] are the column-0 base signal delayed j cycles through registers; bit 0 is undelayed.
- Column j therefore switches mode exactly after its own last beat of the previous pass.

PRELOAD / ACCUM:
- Base acc_en = 0 in PRELOAD, 1 in ACCUM.
- Each psum_en_i=1 increments beat.
- psum_en_i=1 with beat=COL_NUM-1: beat <- 0 and pass <- pass+1.
  - If pass was PASS_NUM-1 -> SETTLE.
  - Else, if in PRELOAD -> ACCUM.
- PASS_NUM=1 goes PRELOAD -> SETTLE directly.
- Gaps in psum_en_i are allowed; the counters hold.

SETTLE:
- Waits PE_SIZE cycles so the last column's final write lands (PE_SIZE-1 skew + 1 write latency), then -> DRAIN.
- acc_en_o holds its last value.

DRAIN:
- Issues COL_NUM reads.
- drain_rd_o = all-ones when reads_remaining>0 and (!ofmap_valid_o | ofmap_ready_i).
- ofmap_valid_o is set the cycle after a read (FIFO read latency 1).
- ofmap_valid_o clears on a handshake with no new read.
- The FIFO holds rdata while not read, so valid stays stable under backpressure.
- After the last handshake -> DONE.

DONE:
- done_o=1 for one cycle.
- Base fifo_clr pulse, skewed per column as above.
- -> IDLE.

Errors and boundaries:
- err_o set by psum_en_i=1 in IDLE, SETTLE, DRAIN or DONE; that beat is not counted.
- err_o set by start_i=1 while busy; the start is ignored.
- pass_idx_o = pass counter; equals PASS_NUM in SETTLE/DRAIN/DONE.
- Reset mid-operation: immediate return to IDLE; no done_o; skew registers cleared.
- Width rule: counters compare against COL_NUM-1 and PASS_NUM-1 truncated to CNT_W; no wrap within a tile.

Test Plan:
(PE_SIZE=4, COL_NUM=5, PASS_NUM=3)
- Start then 15 contiguous psum_en_i beats:
  - acc_en_o[0] rises the cycle after beat 5.
  - acc_en_o[3] rises 3 cycles later.
  - SETTLE after beat 15, DRAIN 4 cycles later.
- Drain with ofmap_ready_i=1: drain_rd_o=1111 for 5 consecutive cycles, ofmap_valid_o for 5 cycles lagging by 1, then done_o pulse, busy_o=0.
- Drain with ofmap_ready_i toggling 1,0,0,1...: exactly 5 handshakes, valid never drops without a handshake, no read while valid&!ready.
- psum_en_i with a 2-cycle gap after beat 3 of pass 1: pass boundary still at the 10th beat, pass_idx_o=2 afterwards.
- psum_en_i pulse in IDLE and start_i during ACCUM: err_o=1 and stays 1; FSM unaffected; next start_i in IDLE clears err_o.
- rst asserted mid-ACCUM at pass 1 beat 2: all outputs 0 asynchronously; new start_i runs a full tile correctly; fifo_clr_o[3] pulses 3 cycles after fifo_clr_o[0].
